// File: rtl/mux_tree_pkg.sv
// Shared definitions for the pipelined mux tree.
// The optional select range check is enabled by defining MUX_TREE_PIPE_SEL_CHECK_EN.
package mux_tree_pkg;

  // Largest channel count the tree is expected to be built with.
  localparam int MUX_TREE_MAX_N = 64;

  // Select width / stage count. A two-input tree still needs one stage.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of lanes held by stage k: ceil(n_in / 2^(k+1)).
  // k = -1 yields n_in, i.e. the raw input channels.
  function automatic int lanes_at(input int n_in, input int k);
    return (n_in + (1 << (k + 1)) - 1) >> (k + 1);
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered level of the mux tree: LANES_IN lanes fold into
// ceil(LANES_IN/2) lanes using select bit K, with valid/ready handshake.
// With MUX_TREE_PIPE_SEL_CHECK_EN defined, an error flag rides along with the item.
module mux_tree_stage #(
  parameter int WIDTH     = 8,
  parameter int LANES_IN  = 4,
  parameter int SEL_W     = 2,
  parameter int K         = 0,
  localparam int LANES_OUT = (LANES_IN + 1) / 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // upstream side
  input  logic [LANES_IN*WIDTH-1:0]  i_lanes,
  input  logic [SEL_W-1:0]           i_sel,
  input  logic                       i_valid,
  output logic                       o_ready,
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  input  logic                       i_err,
  output logic                       o_err,
`endif
  // downstream side
  output logic [LANES_OUT*WIDTH-1:0] o_lanes,
  output logic [SEL_W-1:0]           o_sel,
  output logic                       o_valid,
  input  logic                       i_ready
);

  logic [LANES_OUT*WIDTH-1:0] w_mux;
  logic [LANES_OUT*WIDTH-1:0] r_lanes;
  logic [SEL_W-1:0]           r_sel;
  logic                       r_valid;

  // 2:1 lane muxes; an odd trailing lane has no partner and pairs with zero.
  // NOTE: pure continuous assigns with both arms covered, so no latch can form.
  for (genvar j = 0; j < LANES_OUT; j++) begin : g_lane
    if (2 * j + 1 < LANES_IN) begin : g_pair
      assign w_mux[j*WIDTH +: WIDTH] = i_sel[K] ? i_lanes[(2*j+1)*WIDTH +: WIDTH]
                                                : i_lanes[(2*j)*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_mux[j*WIDTH +: WIDTH] = i_sel[K] ? '0 : i_lanes[(2*j)*WIDTH +: WIDTH];
    end
  end

  // Stage accepts when empty or when its contents move on this cycle.
  assign o_ready = !r_valid || i_ready;

  // Stage register: valid follows upstream whenever the stage may load;
  // payload only changes when a real item arrives.
  // NOTE: payload registers are reset too, so outputs read 0 during and after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_lanes <= '0;
      r_sel   <= '0;
    end else if (o_ready) begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      r_valid <= i_valid;
      if (i_valid) begin
        r_lanes <= w_mux;
        r_sel   <= i_sel;
      end
    end
  end

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  logic r_err;

  // Range-error flag travels with its item under the same load condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (o_ready && i_valid) begin
      r_err <= i_err;
    end
  end

  assign o_err = r_err;
`endif

  assign o_lanes = r_lanes;
  assign o_sel   = r_sel;
  assign o_valid = r_valid;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 multiplexer built as a binary tree of registered 2:1 levels,
// one level per select bit, with valid/ready flow control.
// Define MUX_TREE_PIPE_SEL_CHECK_EN to add the sel_err output flagging in_sel >= N_IN.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  localparam int SEL_W = clog2_safe(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  output logic                    sel_err,
`endif
  input  logic                    out_ready
);

  if (N_IN < 2 || N_IN > MUX_TREE_MAX_N || WIDTH < 1) begin : g_param_check
    $error("mux_tree_pipe: unsupported WIDTH=%0d / N_IN=%0d", WIDTH, N_IN);
  end

  // Handshake and sideband chains: index k feeds stage k, index k+1 leaves it.
  logic             w_valid [SEL_W+1];
  logic             w_ready [SEL_W+1];
  logic [SEL_W-1:0] w_sel   [SEL_W+1];

  assign w_valid[0]     = in_valid;
  assign w_sel[0]       = in_sel;
  assign w_ready[SEL_W] = out_ready;
  assign in_ready       = w_ready[0];

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  logic w_err [SEL_W+1];

  // Only a non-power-of-two tree has select codes with no channel behind them.
  if (N_IN == (1 << SEL_W)) begin : g_err_none
    assign w_err[0] = 1'b0;
  end else begin : g_err_cmp
    assign w_err[0] = (in_sel >= SEL_W'(N_IN));
  end

  assign sel_err = w_err[SEL_W];
`endif

  // One registered tree level per select bit; lane buses shrink by half each level.
  for (genvar k = 0; k < SEL_W; k++) begin : g_stage
    localparam int LANES_IN  = lanes_at(N_IN, k - 1);
    localparam int LANES_OUT = lanes_at(N_IN, k);

    logic [LANES_IN*WIDTH-1:0]  w_lanes_in;
    logic [LANES_OUT*WIDTH-1:0] w_lanes;

    if (k == 0) begin : g_src
      assign w_lanes_in = in_data;
    end else begin : g_src
      assign w_lanes_in = g_stage[k-1].w_lanes;
    end

    mux_tree_stage #(
      .WIDTH    (WIDTH),
      .LANES_IN (LANES_IN),
      .SEL_W    (SEL_W),
      .K        (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_lanes (w_lanes_in),
      .i_sel   (w_sel[k]),
      .i_valid (w_valid[k]),
      .o_ready (w_ready[k]),
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
      .i_err   (w_err[k]),
      .o_err   (w_err[k+1]),
`endif
      .o_lanes (w_lanes),
      .o_sel   (w_sel[k+1]),
      .o_valid (w_valid[k+1]),
      .i_ready (w_ready[k+1])
    );
  end

  // The last level holds a single lane. Out-of-range selects walk into the
  // zero padding, so a flagged item already carries zero data.
  assign out_data  = g_stage[SEL_W-1].w_lanes;
  assign out_sel   = w_sel[SEL_W];
  assign out_valid = w_valid[SEL_W];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: directed latency/streaming/backpressure/
// reset tests on a 4:1 tree, non-power-of-two checks on a 5:1 tree and a
// randomised scoreboard run on an 8:1 tree.
// Define MUX_TREE_PIPE_SEL_CHECK_EN to also check sel_err.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: N_IN=4, WIDTH=8 ----------------
  logic [31:0] a_in_data;
  logic [1:0]  a_in_sel;
  logic        a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_sel;
  logic        a_out_valid, a_out_ready;
  logic        a_sel_err;

  mux_tree_pipe #(.WIDTH(8), .N_IN(4)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_valid (a_out_valid),
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    .sel_err   (a_sel_err),
`endif
    .out_ready (a_out_ready)
  );

  // ---------------- instance B: N_IN=5, WIDTH=4 ----------------
  logic [19:0] b_in_data;
  logic [2:0]  b_in_sel;
  logic        b_in_valid, b_in_ready;
  logic [3:0]  b_out_data;
  logic [2:0]  b_out_sel;
  logic        b_out_valid, b_out_ready;
  logic        b_sel_err;

  mux_tree_pipe #(.WIDTH(4), .N_IN(5)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_valid (b_out_valid),
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    .sel_err   (b_sel_err),
`endif
    .out_ready (b_out_ready)
  );

  // ---------------- instance C: N_IN=8, WIDTH=16 ----------------
  logic [127:0] c_in_data;
  logic [2:0]   c_in_sel;
  logic         c_in_valid, c_in_ready;
  logic [15:0]  c_out_data;
  logic [2:0]   c_out_sel;
  logic         c_out_valid, c_out_ready;
  logic         c_sel_err;

  mux_tree_pipe #(.WIDTH(16), .N_IN(8)) u_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (c_in_data),
    .in_sel    (c_in_sel),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .out_data  (c_out_data),
    .out_sel   (c_out_sel),
    .out_valid (c_out_valid),
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    .sel_err   (c_sel_err),
`endif
    .out_ready (c_out_ready)
  );

  // ---------------- scoreboards ----------------
  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  sel;
  } item_t;

  item_t a_q[$];
  item_t c_q[$];

  logic [7:0] a_chan [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  logic [7:0] a_prev_data;
  logic [1:0] a_prev_sel;
  logic       a_stalled = 1'b0;
  int         c_pops = 0;

  // Monitor A on the falling edge: stability while stalled, pop on output
  // transfer, push on input transfer (both transfers happen at the next rise).
  always @(negedge clk) begin
    if (!rst_n) begin
      a_stalled = 1'b0;
    end else begin
      if (a_stalled) begin
        check("a_hold_valid", 64'(a_out_valid), 64'(1'b1));
        check("a_hold_data", 64'(a_out_data), 64'(a_prev_data));
        check("a_hold_sel", 64'(a_out_sel), 64'(a_prev_sel));
      end
      a_stalled   = a_out_valid && !a_out_ready;
      a_prev_data = a_out_data;
      a_prev_sel  = a_out_sel;
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          check("a_spurious_out", 64'(a_out_valid), 64'(1'b0));
        end else begin
          item_t e;
          e = a_q.pop_front();
          check("a_sb_data", 64'(a_out_data), 64'(e.data));
          check("a_sb_sel", 64'(a_out_sel), 64'(e.sel));
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
          check("a_sb_err", 64'(a_sel_err), 64'(1'b0));
`endif
        end
      end
      if (a_in_valid && a_in_ready) begin
        item_t n;
        n.data = 16'(a_chan[a_in_sel]);
        n.sel  = 3'(a_in_sel);
        a_q.push_back(n);
      end
    end
  end

  // Monitor C: same scheme, model is a plain indexed slice of the input bus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (c_out_valid && c_out_ready) begin
        if (c_q.size() == 0) begin
          check("c_spurious_out", 64'(c_out_valid), 64'(1'b0));
        end else begin
          item_t e;
          e = c_q.pop_front();
          c_pops++;
          check("c_sb_data", 64'(c_out_data), 64'(e.data));
          check("c_sb_sel", 64'(c_out_sel), 64'(e.sel));
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
          check("c_sb_err", 64'(c_sel_err), 64'(1'b0));
`endif
        end
      end
      if (c_in_valid && c_in_ready) begin
        item_t n;
        n.data = c_in_data[c_in_sel*16 +: 16];
        n.sel  = c_in_sel;
        c_q.push_back(n);
      end
    end
  end

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = 32'hDDCCBBAA; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = {4'h9, 4'h7, 4'h5, 4'h3, 4'h1}; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;

    // ---- reset values ----
    repeat (3) step();
    check("rst_a_valid", 64'(a_out_valid), 64'(1'b0));
    check("rst_a_data", 64'(a_out_data), 64'(8'h00));
    check("rst_a_sel", 64'(a_out_sel), 64'(2'd0));
    check("rst_b_valid", 64'(b_out_valid), 64'(1'b0));
    check("rst_c_valid", 64'(c_out_valid), 64'(1'b0));
    rst_n = 1'b1;
    #1;
    check("a_in_ready_idle", 64'(a_in_ready), 64'(1'b1));

    // ---- single item latency ----
    step();
    a_in_sel = 2'd2; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(a_out_valid), 64'(1'b0));
    step();
    check("lat_cycle2_valid", 64'(a_out_valid), 64'(1'b1));
    check("lat_cycle2_data", 64'(a_out_data), 64'(8'hCC));
    check("lat_cycle2_sel", 64'(a_out_sel), 64'(2'd2));
    step();
    check("lat_after_valid", 64'(a_out_valid), 64'(1'b0));

    // ---- streaming, sel 0,1,2,3,... back to back ----
    for (int i = 0; i < 12; i++) begin
      a_in_valid = (i < 10);
      a_in_sel   = 2'(i % 4);
      check("stream_in_ready", 64'(a_in_ready), 64'(1'b1));
      if (i >= 2) begin
        check("stream_valid", 64'(a_out_valid), 64'(1'b1));
        check("stream_data", 64'(a_out_data), 64'(a_chan[(i - 2) % 4]));
      end
      step();
    end
    a_in_valid = 1'b0;
    check("stream_done_valid", 64'(a_out_valid), 64'(1'b0));

    // ---- backpressure ----
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd0;
    check("bp_accept0", 64'(a_in_ready), 64'(1'b1));
    step();
    a_in_sel = 2'd1;
    check("bp_accept1", 64'(a_in_ready), 64'(1'b1));
    step();
    a_in_sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      check("bp_full_ready", 64'(a_in_ready), 64'(1'b0));
      check("bp_full_valid", 64'(a_out_valid), 64'(1'b1));
      check("bp_full_data", 64'(a_out_data), 64'(8'hAA));
      step();
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_shift_ready", 64'(a_in_ready), 64'(1'b1));
    for (int n = 3; n < 6; n++) begin
      step();
      a_in_sel = 2'(n % 4);
      check("bp_stream_ready", 64'(a_in_ready), 64'(1'b1));
    end
    step();
    a_in_valid = 1'b0;
    repeat (4) step();
    check("bp_drained", 64'(a_q.size()), 64'(0));

    // ---- reset with two items in flight ----
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd1;
    step();
    a_in_sel = 2'd3;
    step();
    a_in_valid = 1'b0;
    check("mid_pre_valid", 64'(a_out_valid), 64'(1'b1));
    #1;
    rst_n = 1'b0;
    a_q.delete();
    #1;
    check("mid_rst_valid", 64'(a_out_valid), 64'(1'b0));
    check("mid_rst_data", 64'(a_out_data), 64'(8'h00));
    step();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_stale", 64'(a_out_valid), 64'(1'b0));
    end
    a_in_sel = 2'd3; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("mid_lat1_valid", 64'(a_out_valid), 64'(1'b0));
    step();
    check("mid_lat2_valid", 64'(a_out_valid), 64'(1'b1));
    check("mid_lat2_data", 64'(a_out_data), 64'(8'hDD));
    step();

    // ---- non-power-of-two: N_IN=5, three stages ----
    b_in_sel = 3'd4; b_in_valid = 1'b1;
    step();
    b_in_sel = 3'd6;
    step();
    b_in_valid = 1'b0;
    check("np2_lat2_valid", 64'(b_out_valid), 64'(1'b0));
    step();
    check("np2_in_range_valid", 64'(b_out_valid), 64'(1'b1));
    check("np2_in_range_data", 64'(b_out_data), 64'(4'h9));
    check("np2_in_range_sel", 64'(b_out_sel), 64'(3'd4));
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    check("np2_in_range_err", 64'(b_sel_err), 64'(1'b0));
`endif
    step();
    check("np2_oob_valid", 64'(b_out_valid), 64'(1'b1));
    check("np2_oob_data", 64'(b_out_data), 64'(4'h0));
    check("np2_oob_sel", 64'(b_out_sel), 64'(3'd6));
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    check("np2_oob_err", 64'(b_sel_err), 64'(1'b1));
`endif
    step();
    check("np2_done_valid", 64'(b_out_valid), 64'(1'b0));

    // ---- randomised scoreboard run on the 8:1 tree ----
    for (int cyc = 0; cyc < 10000; cyc++) begin
      c_in_valid  = 1'($urandom_range(0, 1));
      c_out_ready = ($urandom_range(0, 3) != 0);
      c_in_sel    = 3'($urandom_range(0, 7));
      c_in_data   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    repeat (6) step();
    check("rand_drained", 64'(c_q.size()), 64'(0));
    check("rand_had_traffic", 64'(c_pops > 1000), 64'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised N:1 multiplexer for WIDTH-bit data. Built as a binary tree of 2:1 stages, one registered tree level per select bit.
- Successor to the team's fixed 4:1 tree built from 2:1 muxes. Each level uses its own select bit; earlier revision bug, where one sel drove every level, is fixed.
- Adds valid/ready flow control with full throughput and backpressure.
- Sits between multi-source datapaths and a single consumer.

Parameters:
- WIDTH, 8, data width per input channel (>=1).
- N_IN, 4, number of input channels (>=2; non-power-of-two allowed).
- SEL_W, $clog2(N_IN), select width and number of pipeline stages (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*WIDTH  flattened channels; channel i at [i*WIDTH +: WIDTH].
- in_sel  input  SEL_W  channel index, sampled with in_valid.
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  block accepts this cycle.
- out_data  output  WIDTH  selected channel data.
- out_sel  output  SEL_W  in_sel that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_data=0, out_sel=0, out_valid=0, and all internal stage valids and data 0. in_ready=1 once rst_n is high, because it is combinational from empty stages.
- Structure:
  - Stage k (k=0..SEL_W-1) holds N_IN/2^(k+1) lanes (rounded up), a valid bit, and the full sel.
  - Stage k lane j = sel[k] ? prev lane 2j+1 : prev lane 2j.
  - The final stage register drives the outputs directly.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage advance rule: ready_k = !valid_k || ready_(k+1), with ready_SEL_W = out_ready. When ready_k is high, stage k loads from stage k-1 (or the input), and valid_k <= valid_(k-1).
- in_ready = ready_0 (combinational; no combinational in_valid->in_ready path).
- Latency: exactly SEL_W cycles from input transfer to out_valid when out_ready is held high.
- Throughput: 1 transfer/cycle sustained. Capacity is SEL_W items in flight.
- Backpressure:
  - When out_ready=0 and all stages are valid, in_ready=0. Data and sel in every stage hold stable.
  - Bubbles collapse: an empty stage loads even while downstream is stalled.
- AXI-style stability: once out_valid=1, out_data and out_sel stay stable until the transfer completes.
- Non-power-of-two N_IN: missing leaves read as 0. in_sel >= N_IN yields out_data=0 (see optional feature).
- Mid-operation reset: all in-flight items are discarded and out_valid drops asynchronously. No partial item emerges after release.
- Simultaneous input and output transfer on a full pipe: the pipe shifts by one, and in_ready remains 1.
- N_IN=2 degenerates to a single registered stage, latency 1.

Optional Feature:
- Macro MUX_TREE_PIPE_SEL_CHECK_EN.
- Defined:
  - Adds output port sel_err (1 bit, reset 0).
  - sel_err is asserted alongside out_valid for an item whose in_sel >= N_IN, and travels with the item through the pipe.
  - out_data for that item is forced to 0.
- Undefined: no sel_err port, no range compare. Out-of-range selects still return the zero padding.
- Power-of-two N_IN: sel_err is constant 0.

Decomposition:
- Shared package mux_tree_pkg: function clog2_safe (returns 1 for N=2) and localparam MUX_TREE_MAX_N=64 for elaboration assertions.
- One sub-module, mux_tree_stage, parametrised by lane count, WIDTH, SEL_W and stage index K. It contains the 2:1 lane muxes, the stage register, the valid bit and the ready logic.
- The top level generates SEL_W instances of mux_tree_stage and flattens the lane buses.

Test Plan:
- Reset/latency (N_IN=4, WIDTH=8):
  - Stimulus: after reset, in_data={8'hDD,8'hCC,8'hBB,8'hAA}, in_sel=2, in_valid=1 for one cycle, out_ready=1.
  - Response: out_valid=1 exactly 2 cycles later with out_data=8'hCC and out_sel=2.
  - Outputs are 0 throughout reset.
- Streaming:
  - Stimulus: in_sel=0,1,2,3,0,... on back-to-back cycles.
  - Response: out_data=AA,BB,CC,DD,AA,... consecutively with no gaps, and in_ready held at 1.
- Backpressure:
  - Stimulus: out_ready=0 with the stream running.
  - Response: after 2 accepts, in_ready=0 and out_data holds stable for 5 stalled cycles. Release out_ready: items emerge in order with no loss or duplication.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 while 2 items are in flight.
  - Response: out_valid drops immediately. After release, no stale item appears, and the next item has latency 2.
- Non-power-of-two (N_IN=5, WIDTH=4, SEL_W=3):
  - Stimulus: in_sel=4 selecting channel value 4'h9, then in_sel=6.
  - Response: out_data=9 after 3 cycles, then out_data=0.
  - With MUX_TREE_PIPE_SEL_CHECK_EN: sel_err=0 for the first item and 1 for the second.
- Randomised scoreboard:
  - Stimulus: random in_valid, out_ready, in_sel and data for 10k cycles at N_IN=8, WIDTH=16.
  - Response: the output sequence matches the reference queue exactly.
